irq_source_ctrl: RTL and testbench
==================================

Name: irq_source_ctrl

Overview:
- Peripheral-side interrupt controller that drives the CPU program counter's three interrupt request lines.
- Collects up to 7 peripheral request lines, latches them as pending events, masks them and picks the highest priority one.
- Presents the winner as a 3-bit vector code on irq3..irq1 (code 1..7 selects CPU vector address 2..8).
- Tracks the CPU's in-service flag and end-of-interrupt pulse so each request is delivered exactly once.

Parameters:
- MASK_RST, 7'h7F, reset value of the enable mask (bit set = source enabled).
- ACK_TIMEOUT, 255, cycles to wait in PRESENT for CPU acceptance before withdrawing the code; range 1..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  7  peripheral request lines; req[i] maps to code i+1.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  7  new mask value, taken when mask_we=1.
- inter  in  1  CPU in-service flag (high while an interrupt routine runs).
- eirq  in  1  CPU end-of-interrupt pulse.
- irq1  out  1  code bit 0.
- irq2  out  1  code bit 1.
- irq3  out  1  code bit 2.
- mask  out  7  current enable mask.
- pending  out  7  latched pending events.
- active_code  out  3  code currently presented or in service; 0 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset state: state=IDLE; irq1..3=0; pending=0; mask=MASK_RST; active_code=0; busy=0; req edge register=0; timeout counter=0.
- Reset wins over every other event, including mid-PRESENT and mid-SERVICE.
- Edge detect: req_d is registered each cycle. A rise (req & ~req_d) sets the corresponding pending bit on the next edge.
- Masked sources still latch pending but are not eligible. A level held high produces one event only.
- Mask write: mask takes mask_wdata on the next edge. It affects only arbitration in IDLE; a code already presented or in service is not withdrawn.
- Priority: highest index wins. Eligible set = pending & mask; winner = index of its MSB; code = winner+1.
- All outputs are registered. irq1..3 = {irq3,irq2,irq1} = code in PRESENT only, and 0 in all other states.
- IDLE:
  - If eligible != 0: latch code into active_code, clear timeout counter, go to PRESENT.
  - irq lines go high on the cycle after the decision, so there is 1 cycle of latency from a pending bit to the irq lines.
- PRESENT:
  - If inter=1: clear pending[active_code-1], drive irq lines to 0, go to SERVICE.
  - Else if counter == ACK_TIMEOUT-1: drive irq lines to 0, keep the pending bit, set active_code=0, go to IDLE (re-arbitration takes place there).
  - Else increment the counter.
  - eirq is ignored in this state.
- SERVICE:
  - Irq lines held 0. Wait for eirq=1, then set active_code=0 and go to GAP.
  - A new rise on any req, including the serviced source, re-sets pending and is delivered after this service completes.
- GAP: wait for inter=0 (at least 1 cycle in GAP), then go to IDLE. This prevents a new code from being presented while the CPU's in-service bookkeeping is still clearing.
- Simultaneous set and clear on the same pending bit in the same cycle: set wins, so the new event is kept.
- A rise on req while the same bit is already pending merges into that one event; no count is kept.
- Counter width is 16 bits and never wraps; it saturates at the timeout compare.

Test Plan:
- Reset, mask=7F, pulse req[2] for 1 cycle, hold inter=0 → 2 cycles later irq3..1=3'b011; pending=7'h04; busy=1.
- In the previous case, raise inter → next cycle irq=0 and pending=0. Pulse eirq, drop inter → IDLE; busy=0 one cycle after inter=0.
- req[0] and req[5] rise in the same cycle → code 6 is presented first; after service and GAP, code 1 is presented.
- mask_wdata=7'h7E, pulse req[0] → pending=01, irq stays 0. Then write mask 7F → code 1 is presented 2 cycles after the write.
- ACK_TIMEOUT=4, pulse req[3], hold inter=0 → code 4 is presented for 4 cycles, drops to 0, then re-presents; pending[3] stays 1 throughout.
- Assert rst during SERVICE with req[1] pending → next cycle all outputs at reset values; pending=0; mask=MASK_RST.

Source files
------------

// File: rtl/irq_source_ctrl.sv
// Peripheral interrupt source controller: latches request edges, masks, prioritises
// and hands a 3-bit vector code to the CPU with an in-service/EOI handshake.
module irq_source_ctrl #(
    parameter logic [6:0]  MASK_RST    = 7'h7F,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] req,
    input  logic       mask_we,
    input  logic [6:0] mask_wdata,
    input  logic       inter,
    input  logic       eirq,
    output logic       irq1,
    output logic       irq2,
    output logic       irq3,
    output logic [6:0] mask,
    output logic [6:0] pending,
    output logic [2:0] active_code,
    output logic       busy
);

    localparam int unsigned N_SRC  = 7;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [N_SRC-1:0]  req_d;
    logic [CODE_W-1:0] irq_q, irq_n;
    logic [CODE_W-1:0] act_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [N_SRC-1:0]  pending_n, mask_n, clr, rise, elig;
    logic [CODE_W-1:0] win_code, act_onehot_sel;
    logic              busy_n;

    assign rise = req & ~req_d;
    assign elig = pending & mask;
    assign act_onehot_sel = active_code;

    // Highest eligible index wins; later loop iterations override earlier ones.
    always_comb begin
        win_code = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (elig[i]) win_code = CODE_W'(i + 1);
        end
    end

    always_comb begin
        state_n = state;
        irq_n   = '0;
        act_n   = active_code;
        cnt_n   = cnt;
        clr     = '0;
        unique case (state)
            IDLE: begin
                if (|elig) begin
                    act_n   = win_code;
                    irq_n   = win_code;
                    cnt_n   = '0;
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (inter) begin
                    for (int i = 0; i < int'(N_SRC); i++) begin
                        if (act_onehot_sel == CODE_W'(i + 1)) clr[i] = 1'b1;
                    end
                    state_n = SERVICE;
                end else if (cnt == CNT_LAST) begin
                    act_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    irq_n = active_code;
                end
            end
            SERVICE: begin
                if (eirq) begin
                    act_n   = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (!inter) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A new rise on the bit being cleared is kept as a fresh event.
        pending_n = (pending & ~clr) | rise;
        mask_n    = mask_we ? mask_wdata : mask;
        busy_n    = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_d       <= '0;
            irq_q       <= '0;
            active_code <= '0;
            cnt         <= '0;
            pending     <= '0;
            mask        <= MASK_RST;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            req_d       <= req;
            irq_q       <= irq_n;
            active_code <= act_n;
            cnt         <= cnt_n;
            pending     <= pending_n;
            mask        <= mask_n;
            busy        <= busy_n;
        end
    end

    assign irq1 = irq_q[0];
    assign irq2 = irq_q[1];
    assign irq3 = irq_q[2];

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl with a short acknowledge timeout.
module tb_irq_source_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] req;
    logic       mask_we;
    logic [6:0] mask_wdata;
    logic       inter;
    logic       eirq;
    logic       irq1, irq2, irq3;
    logic [6:0] mask;
    logic [6:0] pending;
    logic [2:0] active_code;
    logic       busy;

    int errors = 0;
    int checks = 0;

    irq_source_ctrl #(.MASK_RST(7'h7F), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .inter(inter), .eirq(eirq), .irq1(irq1), .irq2(irq2), .irq3(irq3),
        .mask(mask), .pending(pending), .active_code(active_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_irq, input logic [6:0] e_pend,
                           input logic [2:0] e_act, input logic e_busy);
        chk({tag, ".irq"}, 32'({irq3, irq2, irq1}), 32'(e_irq));
        chk({tag, ".pending"}, 32'(pending), 32'(e_pend));
        chk({tag, ".active"}, 32'(active_code), 32'(e_act));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        rst = 1'b1; req = '0; mask_we = 1'b0; mask_wdata = '0; inter = 1'b0; eirq = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_all("reset", 3'd0, 7'h00, 3'd0, 1'b0);
        chk("reset.mask", 32'(mask), 32'h7F);

        // Single request, one cycle latency from pending to irq lines
        req = 7'h04; tick();
        chk_all("t1.latch", 3'd0, 7'h04, 3'd0, 1'b0);
        req = 7'h00; tick();
        chk_all("t1.present", 3'd3, 7'h04, 3'd3, 1'b1);
        inter = 1'b1; tick();
        chk_all("t1.accept", 3'd0, 7'h00, 3'd3, 1'b1);
        eirq = 1'b1; tick();
        chk_all("t1.gap", 3'd0, 7'h00, 3'd0, 1'b1);
        eirq = 1'b0; inter = 1'b0; tick();
        chk_all("t1.idle", 3'd0, 7'h00, 3'd0, 1'b0);

        // Two sources rise together: highest index first
        req = 7'h21; tick();
        chk("t2.latch", 32'(pending), 32'h21);
        req = 7'h00; tick();
        chk_all("t2.first", 3'd6, 7'h21, 3'd6, 1'b1);
        inter = 1'b1; tick();
        chk_all("t2.svc6", 3'd0, 7'h01, 3'd6, 1'b1);
        eirq = 1'b1; tick();
        eirq = 1'b0; inter = 1'b0; tick();
        chk_all("t2.idle", 3'd0, 7'h01, 3'd0, 1'b0);
        tick();
        chk_all("t2.second", 3'd1, 7'h01, 3'd1, 1'b1);
        inter = 1'b1; tick();
        chk("t2.svc1", 32'(pending), 32'h00);
        eirq = 1'b1; tick();
        eirq = 1'b0; inter = 1'b0; tick();

        // Masked source latches but is not presented until unmasked
        mask_we = 1'b1; mask_wdata = 7'h7E; tick();
        chk("t3.mask", 32'(mask), 32'h7E);
        mask_we = 1'b0; req = 7'h01; tick();
        req = 7'h00; tick();
        chk_all("t3.masked", 3'd0, 7'h01, 3'd0, 1'b0);
        tick();
        chk_all("t3.masked2", 3'd0, 7'h01, 3'd0, 1'b0);
        mask_we = 1'b1; mask_wdata = 7'h7F; tick();
        chk("t3.wr_irq", 32'({irq3, irq2, irq1}), 32'd0);
        mask_we = 1'b0; tick();
        chk_all("t3.present", 3'd1, 7'h01, 3'd1, 1'b1);
        inter = 1'b1; tick();
        eirq = 1'b1; tick();
        eirq = 1'b0; inter = 1'b0; tick();

        // Acknowledge timeout: four cycles presented, one idle, then re-present
        req = 7'h08; tick();
        req = 7'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("t4.pres%0d", i), 3'd4, 7'h08, 3'd4, 1'b1);
        end
        tick();
        chk_all("t4.withdraw", 3'd0, 7'h08, 3'd0, 1'b0);
        tick();
        chk_all("t4.represent", 3'd4, 7'h08, 3'd4, 1'b1);

        // Accept and a new rise of the same source in one cycle: set wins
        inter = 1'b1; req = 7'h08; tick();
        chk_all("t5.setwins", 3'd0, 7'h08, 3'd4, 1'b1);
        req = 7'h00; eirq = 1'b1; tick();
        eirq = 1'b0; inter = 1'b0; tick();
        tick();
        chk_all("t5.redeliver", 3'd4, 7'h08, 3'd4, 1'b1);

        // Reset during service with another source pending
        inter = 1'b1; mask_we = 1'b1; mask_wdata = 7'h55; tick();
        mask_we = 1'b0; req = 7'h02; tick();
        chk("t6.pend", 32'(pending), 32'h02);
        chk("t6.mask", 32'(mask), 32'h55);
        req = 7'h00; rst = 1'b1; tick();
        chk_all("t6.reset", 3'd0, 7'h00, 3'd0, 1'b0);
        chk("t6.reset.mask", 32'(mask), 32'h7F);
        rst = 1'b0; inter = 1'b0; tick();
        chk_all("t6.after", 3'd0, 7'h00, 3'd0, 1'b0);

        // A held level produces one event only
        req = 7'h40; tick();
        chk("t7.latch", 32'(pending), 32'h40);
        tick();
        chk_all("t7.present", 3'd7, 7'h40, 3'd7, 1'b1);
        inter = 1'b1; tick();
        chk("t7.clr", 32'(pending), 32'h00);
        tick();
        chk("t7.held", 32'(pending), 32'h00);
        eirq = 1'b1; tick();
        eirq = 1'b0; inter = 1'b0; tick();
        tick();
        chk_all("t7.idle", 3'd0, 7'h00, 3'd0, 1'b0);
        req = 7'h00; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
